// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and the counter-width helper.
package seq_multiplier_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Bits needed to hold values 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int bits;
    int v;
    bits = 0;
    v    = value - 1;
    while (v > 0) begin
      bits++;
      v = v >> 1;
    end
    if (bits < 1) bits = 1;
    return bits;
  endfunction

endpackage

// File: rtl/seq_multiplier_dp.sv
// Datapath of seq_multiplier: operand shift registers, accumulator, adder and
// product register. Signed operation is selected by SEQ_MULTIPLIER_SIGNED_EN.
module seq_multiplier_dp
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic                 last,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   p
);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] p_final;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
  logic neg;

  // The most negative input maps to 2^(WIDTH-1), which still fits unsigned.
  assign a_mag   = a[WIDTH-1] ? -a : a;
  assign b_mag   = b[WIDTH-1] ? -b : b;
  assign p_final = neg ? -acc_next : acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    neg <= 1'b0;
    else if (load) neg <= a[WIDTH-1] ^ b[WIDTH-1];
  end
`else
  assign a_mag   = a;
  assign b_mag   = b;
  assign p_final = acc_next;
`endif

  assign acc_next = acc + (mplier[0] ? mcand : '0);

  // NOTE: the operand registers are not observable after reset, but are
  // cleared anyway so a reset always leaves the datapath in a known state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      p      <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, a_mag};
      mplier <= b_mag;
      acc    <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (last) p <= p_final;
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential WIDTH x WIDTH shift-and-add multiplier with start/busy/done
// handshake. Define SEQ_MULTIPLIER_SIGNED_EN for two's-complement operands.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int CW = clog2(WIDTH);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;
  logic          load;
  logic          step;
  logic          last;

  assign load = (state == ST_IDLE) && start;
  assign step = (state == ST_RUN);
  assign last = (count == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // One RUN cycle per multiplier bit: count runs WIDTH-1 down to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             count <= '0;
    else if (load)          count <= CW'(WIDTH - 1);
    else if (step && !last) count <= count - 1'b1;
  end

  // NOTE: a default assignment up front keeps this block free of latches.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last)  state_next = ST_DONE;
      ST_DONE:            state_next = ST_IDLE;
      default:            state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN) || (state == ST_DONE);
    done = (state == ST_DONE);
  end

  seq_multiplier_dp #(.WIDTH(WIDTH)) u_dp (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
    .last  (last),
    .a     (a),
    .b     (b),
    .p     (p)
  );

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomised scoreboard bench for seq_multiplier; follows
// SEQ_MULTIPLIER_SIGNED_EN for the reference arithmetic.
module tb_seq_multiplier;

  localparam int WIDTH = 8;
  localparam int PW    = 2 * WIDTH;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [PW-1:0]    p;

  int n_checks = 0;
  int n_pass   = 0;

  logic [PW-1:0] sb[$];
  logic [PW-1:0] p_hold;
  bit            have_op;
  int            cyc;
  int            acc_cyc;

  seq_multiplier #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference product straight from integer arithmetic, reduced to 2*WIDTH bits.
  function automatic logic [PW-1:0] ref_mul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    longint vx;
    longint vy;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    vx = longint'($signed(x));
    vy = longint'($signed(y));
`else
    vx = longint'(x);
    vy = longint'(y);
`endif
    return PW'(vx * vy);
  endfunction

  // Timing model + monitor: an operation accepted at edge A is busy for
  // edges A..A+WIDTH, pulses done at A+WIDTH; next accept at A+WIDTH+2.
  initial begin
    cyc     = 0;
    acc_cyc = 0;
    have_op = 1'b0;
    p_hold  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        have_op = 1'b0;
        sb.delete();
        p_hold = '0;
      end else if (start && (!have_op || cyc >= acc_cyc + WIDTH + 2)) begin
        have_op = 1'b1;
        acc_cyc = cyc;
        sb.push_back(ref_mul(a, b));
      end
      @(negedge clk);
      if (!rst_n) begin
        have_op = 1'b0;
        sb.delete();
        p_hold = '0;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_p", p, 0);
      end else begin
        check("busy", busy, have_op && cyc >= acc_cyc && cyc <= acc_cyc + WIDTH);
        check("done", done, have_op && cyc == acc_cyc + WIDTH);
        if (done) begin
          if (sb.size() == 0) check("done_without_request", 1, 0);
          else p_hold = sb.pop_front();
        end
        check("p", p, p_hold);
      end
    end
  end

  task automatic pulse(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    @(posedge clk); #2;
    start = 1'b1;
    a     = x;
    b     = y;
    @(posedge clk); #2;
    start = 1'b0;
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
  endtask

  // Issue one operation, optionally poke start while it runs, then idle `gap` cycles.
  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input int gap, input bit spurious);
    pulse(x, y);
    if (spurious) begin
      pulse(WIDTH'(8'h55), WIDTH'($urandom));
      repeat (WIDTH - 1 + gap) @(posedge clk);
    end else begin
      repeat (WIDTH + gap) @(posedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk); #2;
    rst_n = 1'b1;

    issue(WIDTH'(8'hFF), WIDTH'(8'hFF), 20, 1'b0);
    issue(WIDTH'(8'h00), WIDTH'(8'hA5), 0, 1'b0);
    issue(WIDTH'(8'h0C), WIDTH'(8'h0D), 2, 1'b1);
    issue(WIDTH'(8'hFD), WIDTH'(8'h05), 0, 1'b0);
    issue(WIDTH'(8'h80), WIDTH'(8'h80), 0, 1'b0);
    issue(WIDTH'(8'h80), WIDTH'(8'h7F), 1, 1'b0);
    issue(WIDTH'(8'h7F), WIDTH'(8'h7F), 3, 1'b0);

    // Abort an operation with reset four edges after acceptance.
    pulse(WIDTH'(8'h10), WIDTH'(8'h10));
    repeat (4) @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #2;
    rst_n = 1'b1;
    issue(WIDTH'(8'h03), WIDTH'(8'h07), 2, 1'b0);

    // start held high: a new operation on every return to IDLE.
    @(posedge clk); #2;
    start = 1'b1;
    a     = '1;
    b     = ~WIDTH'(1);
    repeat (3 * (WIDTH + 2) + 1) @(posedge clk); #2;
    start = 1'b0;
    repeat (WIDTH + 4) @(posedge clk);

    for (int i = 0; i < 40; i++)
      issue(WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));

    repeat (WIDTH + 4) @(posedge clk);
    check("scoreboard_drained", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
